// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared states, default widths and lane helper for the serial divider
package divider_pkg;

  localparam int DEF_A_WIDTH  = 32;
  localparam int DEF_B_WIDTH  = 16;
  localparam int DEF_IN_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_READY,
    ST_RUN,
    ST_DONE
  } state_e;

  function automatic int lane_count(input int width, input int lane_w);
    return width / lane_w;
  endfunction

endpackage

// File: rtl/restoring_div_core.sv
// rtl/restoring_div_core.sv - iterative unsigned restoring divider, one quotient bit per cycle
module restoring_div_core #(
  parameter int A_WIDTH = 32,
  parameter int B_WIDTH = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               go,
  input  logic               abort,
  input  logic [A_WIDTH-1:0] dividend,
  input  logic [B_WIDTH-1:0] divisor,
  output logic [A_WIDTH-1:0] quotient,
  output logic [B_WIDTH-1:0] remainder,
  output logic               last
);

  localparam int CW = $clog2(A_WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(A_WIDTH - 1);

  logic [A_WIDTH-1:0] quo_q, quo_d;
  logic [B_WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               run_q, run_d;
  logic [B_WIDTH:0]   shifted, trial;
  logic               fits;

  // quotient/remainder show the result of the step in progress, so the
  // caller can capture the final answer on the same edge as the last step
  always_comb begin
    shifted   = {rem_q, quo_q[A_WIDTH-1]};
    trial     = shifted - {1'b0, divisor};
    fits      = ~trial[B_WIDTH];
    remainder = fits ? trial[B_WIDTH-1:0] : shifted[B_WIDTH-1:0];
    quotient  = {quo_q[A_WIDTH-2:0], fits};
    last      = run_q && (cnt_q == LAST_ITER);

    quo_d = quo_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (abort) begin
      run_d = 1'b0;
      cnt_d = '0;
    end else if (go) begin
      quo_d = dividend;
      rem_d = '0;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      quo_d = quotient;
      rem_d = remainder;
      cnt_d = cnt_q + 1'b1;
      run_d = ~last;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      quo_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/serial_divider_controller.sv
// rtl/serial_divider_controller.sv - byte-serial operand loading, divide control and result readback
module serial_divider_controller
  import divider_pkg::*;
#(
  parameter  int A_WIDTH  = DEF_A_WIDTH,
  parameter  int B_WIDTH  = DEF_B_WIDTH,
  parameter  int IN_WIDTH = DEF_IN_WIDTH,
  localparam int NA       = lane_count(A_WIDTH, IN_WIDTH),
  localparam int NB       = lane_count(B_WIDTH, IN_WIDTH),
  localparam int NR       = NA + NB,
  localparam int CNT_W    = $clog2(NR + 1),
  localparam int SEL_W    = $clog2(NR)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [IN_WIDTH-1:0] inp,
  input  logic                set,
  input  logic                clear,
  input  logic                start,
  input  logic [SEL_W-1:0]    sel,
  output logic [IN_WIDTH-1:0] out,
  output logic [CNT_W-1:0]    load_count,
  output logic                busy,
  output logic                done,
  output logic                div_by_zero
);

  localparam int RW = NR * IN_WIDTH;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(NR - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [RW-1:0]      ops_q, ops_d, res_q, res_d;
  logic               dbz_q, dbz_d;
  logic               set_q;
  logic               set_edge, go, core_last;
  logic [A_WIDTH-1:0] dividend, core_quo;
  logic [B_WIDTH-1:0] divisor, core_rem;

  assign dividend = ops_q[A_WIDTH-1:0];
  assign divisor  = ops_q[RW-1:A_WIDTH];
  assign set_edge = set & ~set_q;

  restoring_div_core #(
    .A_WIDTH(A_WIDTH),
    .B_WIDTH(B_WIDTH)
  ) u_core (
    .clock    (clock),
    .reset    (reset),
    .go       (go),
    .abort    (clear),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (core_quo),
    .remainder(core_rem),
    .last     (core_last)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ops_d   = ops_q;
    res_d   = res_q;
    dbz_d   = dbz_q;
    go      = 1'b0;
    if (clear) begin
      state_d = ST_LOAD;
      count_d = '0;
      ops_d   = '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (set_edge) begin
            ops_d[count_q*IN_WIDTH +: IN_WIDTH] = inp;
            count_d = count_q + 1'b1;
            if (count_q == LAST_LANE) state_d = ST_READY;
          end
        end
        ST_READY, ST_DONE: begin
          if (start) begin
            if (divisor != '0) begin
              state_d = ST_RUN;
              go      = 1'b1;
            end else begin
              state_d = ST_DONE;
              res_d   = {B_WIDTH'(dividend), {A_WIDTH{1'b1}}};
              dbz_d   = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (core_last) begin
            state_d = ST_DONE;
            res_d   = {core_rem, core_quo};
            dbz_d   = 1'b0;
          end
        end
        default: state_d = ST_LOAD;
      endcase
    end
  end

  // set_q resets high so a set line already high at reset release does not load
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_LOAD;
      count_q <= '0;
      ops_q   <= '0;
      res_q   <= '0;
      dbz_q   <= 1'b0;
      set_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ops_q   <= ops_d;
      res_q   <= res_d;
      dbz_q   <= dbz_d;
      set_q   <= set;
    end
  end

  always_comb begin
    out = '0;
    if (int'(sel) < NR) out = res_q[sel*IN_WIDTH +: IN_WIDTH];
  end

  assign load_count  = count_q;
  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_serial_divider_controller.sv
// tb/tb_serial_divider_controller.sv - self-checking bench for default and narrow divider configurations
module tb_serial_divider_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] a_inp, a_out;
  logic       a_set, a_clear, a_start, a_busy, a_done, a_dbz;
  logic [2:0] a_sel, a_cnt;
  logic [3:0] b_inp, b_out;
  logic       b_set, b_clear, b_start, b_busy, b_done, b_dbz;
  logic [2:0] b_sel, b_cnt;

  int checks = 0;
  int errors = 0;

  serial_divider_controller dut_a (
    .clock(clk), .reset(reset), .inp(a_inp), .set(a_set), .clear(a_clear),
    .start(a_start), .sel(a_sel), .out(a_out), .load_count(a_cnt),
    .busy(a_busy), .done(a_done), .div_by_zero(a_dbz)
  );

  serial_divider_controller #(.A_WIDTH(16), .B_WIDTH(8), .IN_WIDTH(4)) dut_b (
    .clock(clk), .reset(reset), .inp(b_inp), .set(b_set), .clear(b_clear),
    .start(b_start), .sel(b_sel), .out(b_out), .load_count(b_cnt),
    .busy(b_busy), .done(b_done), .div_by_zero(b_dbz)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference: packed {remainder, quotient}; divide by zero gives all-ones quotient
  function automatic logic [47:0] model_a(input logic [31:0] a, input logic [15:0] b);
    if (b == 0) return {a[15:0], 32'hFFFF_FFFF};
    return {16'(a % b), a / b};
  endfunction

  function automatic logic [23:0] model_b(input logic [15:0] a, input logic [7:0] b);
    if (b == 0) return {a[7:0], 16'hFFFF};
    return {8'(a % b), a / b};
  endfunction

  task automatic load_a(input logic [47:0] ops, input int from);
    for (int i = from; i < 6; i++) begin
      a_inp = ops[i*8 +: 8];
      a_set = 1'b1;
      tick();
      a_set = 1'b0;
      check($sformatf("a_load_count%0d", i), a_cnt, i + 1);
      tick();
    end
  endtask

  task automatic load_b(input logic [23:0] ops);
    for (int i = 0; i < 6; i++) begin
      b_inp = ops[i*4 +: 4];
      b_set = 1'b1;
      tick();
      b_set = 1'b0;
      check($sformatf("b_load_count%0d", i), b_cnt, i + 1);
      tick();
    end
  endtask

  task automatic run_a(input logic [31:0] a, input logic [15:0] b);
    logic [47:0] exp_res;
    exp_res = model_a(a, b);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    if (b != 0) begin
      for (int k = 1; k <= 32; k++) begin
        check("a_busy_run", a_busy, 1);
        check("a_done_run", a_done, 0);
        tick();
      end
      check("a_dbz", a_dbz, 0);
    end else begin
      check("a_dbz", a_dbz, 1);
    end
    check("a_done", a_done, 1);
    check("a_busy_done", a_busy, 0);
    for (int s = 0; s < 8; s++) begin
      a_sel = 3'(s);
      #1;
      check($sformatf("a_lane%0d", s), a_out, (s < 6) ? ((exp_res >> (8 * s)) & 48'hFF) : 0);
    end
    a_sel = 3'd0;
  endtask

  task automatic run_b(input logic [15:0] a, input logic [7:0] b);
    logic [23:0] exp_res, got;
    exp_res = model_b(a, b);
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    if (b != 0) begin
      for (int k = 1; k <= 16; k++) begin
        check("b_busy_run", b_busy, 1);
        tick();
      end
    end
    check("b_done", b_done, 1);
    check("b_dbz", b_dbz, (b == 0) ? 1 : 0);
    for (int s = 0; s < 8; s++) begin
      b_sel = 3'(s);
      #1;
      if (s < 6) got[s*4 +: 4] = b_out;
      check($sformatf("b_lane%0d", s), b_out, (s < 6) ? ((exp_res >> (4 * s)) & 24'hF) : 0);
    end
    if (b != 0) begin
      check("b_rem_lt_div", (got[23:16] < b) ? 1 : 0, 1);
      check("b_q_times_d_plus_r", 32'(got[15:0]) * 32'(b) + 32'(got[23:16]), 32'(a));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] ops;
    logic [31:0] ra;
    logic [15:0] rb;
    logic [15:0] sa;
    logic [7:0]  sb;
    logic [7:0]  first;

    reset = 1'b1;
    a_inp = '0; a_set = 1'b1; a_clear = 1'b0; a_start = 1'b0; a_sel = '0;
    b_inp = '0; b_set = 1'b1; b_clear = 1'b0; b_start = 1'b0; b_sel = '0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();
    check("reset_set_high_cnt_a", a_cnt, 0);
    check("reset_set_high_cnt_b", b_cnt, 0);
    check("reset_busy", a_busy, 0);
    check("reset_done", a_done, 0);
    check("reset_dbz", a_dbz, 0);
    check("reset_out", a_out, 0);
    a_set = 1'b0;
    b_set = 1'b0;
    tick();

    // Directed default case
    load_a({16'h0100, 32'h1234_5678}, 0);
    run_a(32'h1234_5678, 16'h0100);
    a_sel = 3'd0; #1; check("dir_sel0", a_out, 8'h56);
    a_sel = 3'd4; #1; check("dir_sel4", a_out, 8'h78);
    a_sel = 3'd0;

    // set edges ignored outside LOAD
    a_set = 1'b1; tick(); a_set = 1'b0; tick();
    check("done_set_ignored_cnt", a_cnt, 6);
    check("done_set_ignored_done", a_done, 1);

    // Re-run from DONE with retained operands
    run_a(32'h1234_5678, 16'h0100);

    // Abort at RUN cycle 5
    a_start = 1'b1; tick(); a_start = 1'b0;
    repeat (4) tick();
    check("abort_pre_busy", a_busy, 1);
    a_clear = 1'b1; tick(); a_clear = 1'b0;
    check("abort_busy", a_busy, 0);
    check("abort_done", a_done, 0);
    check("abort_cnt", a_cnt, 0);
    a_sel = 3'd0; #1; check("abort_keep_sel0", a_out, 8'h56);
    a_sel = 3'd4; #1; check("abort_keep_sel4", a_out, 8'h78);
    a_sel = 3'd0;
    repeat (40) tick();
    check("abort_no_result_done", a_done, 0);

    // Divide by zero
    load_a({16'h0000, 32'hDEAD_BEEF}, 0);
    run_a(32'hDEAD_BEEF, 16'h0000);
    a_sel = 3'd4; #1; check("dbz_rem_lo", a_out, 8'hEF);
    a_sel = 3'd5; #1; check("dbz_rem_hi", a_out, 8'hBE);
    a_sel = 3'd0;

    // clear beats start in READY
    a_clear = 1'b1; tick(); a_clear = 1'b0;
    load_a({16'h0003, 32'd100}, 0);
    a_clear = 1'b1; a_start = 1'b1; tick(); a_clear = 1'b0; a_start = 1'b0;
    check("clr_start_cnt", a_cnt, 0);
    check("clr_start_busy", a_busy, 0);
    check("clr_start_done", a_done, 0);
    check("clr_start_dbz_kept", a_dbz, 1);
    tick();
    check("clr_start_busy2", a_busy, 0);

    // set held high for 10 cycles loads only the first lane
    first = 8'($urandom);
    a_inp = first;
    a_set = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      a_inp = 8'($urandom);
    end
    a_set = 1'b0;
    tick();
    check("hold_set_cnt", a_cnt, 1);
    ops = {16'($urandom_range(1, 16'hFFFF)), 32'($urandom)};
    ops[7:0] = first;
    load_a(ops, 1);
    run_a(ops[31:0], ops[47:32]);

    // Random operands, default widths
    for (int n = 0; n < 12; n++) begin
      a_clear = 1'b1; tick(); a_clear = 1'b0;
      ra = 32'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = 16'h0000;
        1:       rb = 16'($urandom_range(1, 255));
        default: rb = 16'($urandom);
      endcase
      if (n == 5) ra = 32'(rb) >> 1;
      load_a({rb, ra}, 0);
      run_a(ra, rb);
    end

    // Random operands, narrow configuration
    for (int n = 0; n < 20; n++) begin
      b_clear = 1'b1; tick(); b_clear = 1'b0;
      sa = 16'($urandom);
      case ($urandom_range(0, 4))
        0:       sb = 8'h00;
        1:       sb = 8'($urandom_range(1, 15));
        default: sb = 8'($urandom);
      endcase
      load_b({sb, sa});
      run_b(sa, sb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_divider_controller.md
# serial_divider_controller

Parametrised operand-loading and result-readback controller for the fixed-point divider path, with its own iterative divide engine. Operands arrive byte-serially on a narrow input bus: each rising edge of `set` loads one lane, dividend lanes first, then divisor lanes. A `start` command launches an unsigned restoring division, and the quotient/remainder lanes are read back through a lane select. Edge detection on `set` replaces the manual lock/unlock scheme. The block adds busy/done status and divide-by-zero handling.

## Interface
- `A_WIDTH`, default 32: dividend and quotient width; must be a multiple of `IN_WIDTH`.
- `B_WIDTH`, default 16: divisor and remainder width; must be a multiple of `IN_WIDTH`.
- `IN_WIDTH`, default 8: lane width of input and output buses.
- Derived constants:
  - NA = A_WIDTH/IN_WIDTH and NB = B_WIDTH/IN_WIDTH.
  - NR = NA+NB.
  - CNT_W = clog2(NR+1) and SEL_W = clog2(NR).
- One clock; reset is synchronous and active-high.
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high; highest priority.
- `inp`  in  IN_WIDTH  operand lane data.
- `set`  in  1  level input; each 0→1 transition loads one lane.
- `clear`  in  1  abandon current state and restart loading.
- `start`  in  1  launch division (honoured in READY and DONE only).
- `sel`  in  SEL_W  readback lane index.
- `out`  out  IN_WIDTH  selected result lane.
- `load_count`  out  CNT_W  lanes loaded so far.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `div_by_zero`  out  1  last completed run had divisor 0.

## Operation
- States are LOAD, READY, RUN and DONE. Reset sends the block to LOAD.
- `set_q` is a registered copy of `set`, updated every cycle, and resets to 1, so `set` held high through reset does not load. Edge = `set & ~set_q`.
- LOAD behaviour:
  - On each edge, `inp` is written to lane `load_count`. Lanes 0..NA-1 form the dividend, LSB lane first; lanes NA..NR-1 form the divisor.
  - `load_count` increments on each load.
  - When the NR-th lane is written, `load_count` becomes NR and the next state is READY.
  - `start` is ignored in LOAD.
- READY/DONE behaviour:
  - Edges on `set` are ignored.
  - If `start` is high and the divisor ≠ 0, go to RUN.
  - If `start` is high and the divisor = 0, go straight to DONE with quotient = all ones, remainder = dividend, `div_by_zero`=1.
  - Re-running from DONE reuses the loaded operands.
- RUN behaviour:
  - Restoring division, one quotient bit per cycle, MSB first, A_WIDTH iterations.
  - `start`, `set` and `sel` have no effect on the engine.
  - After the final iteration the next state is DONE, the result register captures {remainder, quotient} and `div_by_zero` is cleared.
- Result register:
  - Lanes 0..NA-1 hold the quotient; lanes NA..NR-1 hold the remainder.
  - It holds its previous value until DONE is entered.
  - `out` is a combinational mux of the result register by `sel`. An out-of-range `sel` (≥NR) gives 0.
- `clear` behaviour (any state):
  - Next state is LOAD, `load_count` goes to 0 and operands are zeroed.
  - The result register and `div_by_zero` are retained.
  - During RUN, `clear` aborts the run with no result update.
- Priority: `reset` > `clear` > `start` > `set` edge.

## Timing
- Reset values:
  - State LOAD.
  - `load_count`=0, `busy`=0, `done`=0, `div_by_zero`=0, `out`=0 (result register 0).
  - Operands 0, `set_q`=1.
- A lane load is visible in `load_count` the cycle after the edge is sampled.
- READY is entered the cycle after the NR-th edge is sampled.
- `start` sampled at cycle t (divisor ≠ 0):
  - `busy`=1 from t+1 through t+A_WIDTH.
  - `done`=1 and the result is valid from t+A_WIDTH+1.
  - Latency is A_WIDTH+1 cycles.
- `start` sampled at t with divisor = 0: `done`=1 at t+1 and `busy` never asserts.
- `done` stays high in DONE until `start` (drops the next cycle) or `clear`.
- An edge on `set` coincident with `clear` causes no write.
- An edge in the same cycle as the transition into READY cannot occur, since only one edge per cycle is possible.

## Structure
- Package `divider_pkg` holds:
  - the state enum (LOAD, READY, RUN, DONE);
  - a lane-count helper function;
  - the default width constants.
- Sub-module `restoring_div_core`:
  - parameters A_WIDTH and B_WIDTH;
  - ports `clock`, `reset`, `go`, `abort`, `dividend`, `divisor`, `quotient`, `remainder` and `last`.
  - It owns the shift/subtract datapath and the iteration counter.
- The controller owns the FSM, lane loading, edge detection and readback mux.

## Test plan
- Default parameters:
  - Stimulus: load lanes 0x78,0x56,0x34,0x12 (dividend 0x12345678), then 0x00,0x01 (divisor 0x0100); `start`.
  - Required: `done` 33 cycles later; `sel`=0..5 reads 0x56,0x34,0x12,0x00,0x78,0x00.
- Divide by zero:
  - Stimulus: divisor 0x0000, dividend 0xDEADBEEF; `start`.
  - Required: `done` next cycle, `div_by_zero`=1, quotient 0xFFFFFFFF, remainder lanes 0xEF,0xBE (low 16 bits of the dividend).
- Edge detection:
  - Stimulus: hold `set` high 10 cycles with different `inp` values.
  - Required: exactly one lane loaded and `load_count`=1.
  - Stimulus: hold `set` high across reset deassertion.
  - Required: `load_count` stays 0.
- Abort mid-run:
  - Stimulus: `clear` at RUN cycle 5.
  - Required: LOAD next cycle, `busy`=0, the previous result still readable, `load_count`=0.
- Priority and re-run:
  - Stimulus: `clear` and `start` in the same cycle in READY.
  - Required: LOAD, no run.
  - Stimulus: `start` from DONE.
  - Required: identical result after A_WIDTH+1 cycles.
- Parameter sweep:
  - Stimulus: A_WIDTH=16, B_WIDTH=8, IN_WIDTH=4, with random operands checked against a reference model.
  - Required: remainder < divisor, and quotient·divisor + remainder = dividend.
